rand_arbiter: RTL and testbench
===============================

RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
- REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
- REQ-002 The block SHALL have parameter STEPS, default 8, LFSR shifts per grant (1..255).
- REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
- REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
- REQ-005 The block SHALL have port req  input  NREQ  per-requester request, level, held until granted.
- REQ-006 The block SHALL have port gnt  output  NREQ  one-hot grant, registered, one-cycle pulse.
- REQ-007 The block SHALL have port rnd_data  output  8  random byte delivered with gnt, registered.
- REQ-008 The block SHALL have port rnd_valid  output  1  high exactly when gnt is non-zero.
- REQ-009 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
- REQ-010 The block SHALL have, with the configuration macro defined, ports seed_valid  input  1, seed_data  input  8, seed_ready  output  1.

Function
- REQ-011 The block SHALL own one 8-bit LFSR: each step sets s <= {s[4]^s[3]^s[2]^s[0], s[7:1]}.
- REQ-012 The LFSR SHALL step only in STEP state, never in IDLE or GRANT.
- REQ-013 The block SHALL implement FSM states IDLE, STEP, GRANT.
- REQ-014 IDLE with any req bit set SHALL latch the round-robin winner, clear the step counter, and go to STEP.
- REQ-015 Round-robin SHALL pick the first set req bit at or above pointer ptr, wrapping from NREQ-1 to 0; ptr resets to 0.
- REQ-016 STEP SHALL shift once per cycle for exactly STEPS cycles, then go to GRANT.
- REQ-017 In GRANT, if req[winner] is still high, gnt SHALL be one-hot at winner, rnd_valid=1, rnd_data=LFSR value, and ptr SHALL become winner+1 mod NREQ.
- REQ-018 In GRANT, if req[winner] has dropped, the grant SHALL be suppressed (gnt=0, rnd_valid=0, ptr unchanged).
- REQ-019 GRANT SHALL always return to IDLE after one cycle; back-to-back grants SHALL be separated by at least STEPS+1 cycles.
- REQ-020 rnd_data SHALL hold its last delivered value between grants.
- REQ-021 Latency SHALL be fixed: a request first seen in IDLE in cycle N is granted in cycle N+STEPS+1.
- REQ-022 req changes during STEP SHALL NOT change the latched winner.

Reset
- REQ-023 On rst, state=IDLE, LFSR=8'hFF, ptr=0, step counter=0, gnt=0, rnd_valid=0, rnd_data=8'h00, busy=0.
- REQ-024 rst asserted mid-STEP or in GRANT SHALL abort the sequence without issuing a grant; rst SHALL take priority over all other inputs.

Configuration
- REQ-025 Macro RAND_ARBITER_SEED_LOAD_EN SHALL control runtime seeding.
- REQ-026 With the macro defined, seed_ready SHALL be 1 only in IDLE; seed_valid&&seed_ready SHALL load the LFSR with seed_data, or 8'hFF if seed_data==0.
- REQ-027 With the macro defined, a seed load and a new req in the same IDLE cycle SHALL both take effect: load first, then stepping starts from the loaded seed.
- REQ-028 Without the macro, the seed ports SHALL be absent and the LFSR SHALL be seeded only by reset.

Structure
- REQ-029 Package rand_arb_pkg SHALL hold the state enum, the LFSR_RESET=8'hFF constant, and the LFSR next-state function.
- REQ-030 The LFSR SHALL be a sub-module rand_lfsr8 (ports clk, rst, step, load, load_data, q); the arbiter FSM SHALL stay in rand_arbiter.

Verification
- REQ-031 Reset, then req=4'b0001 held: gnt=4'b0001, rnd_data=8'hD0 in cycle N+9 (STEPS=8); sequence 7F,3F,1F,0F,87,43,A1,D0.
- REQ-032 req=4'b1111 held: grants SHALL go 0001, 0010, 0100, 1000, 0001, each 10 cycles apart.
- REQ-033 req[2] alone, dropped in the 4th STEP cycle: no gnt pulse, ptr unchanged, busy falls after GRANT.
- REQ-034 rst pulsed during STEP: no grant, LFSR=FF; the next request again yields 8'hD0.
- REQ-035 (macro defined) seed 8'h00 then req[0]: LFSR is loaded with FF and the grant carries D0; seed 8'h01 then req[0] carries the 8-step value from 01; seed_valid outside IDLE is ignored.

Source files
------------

// File: rtl/rand_arb_pkg.sv
// Shared types and helpers for the random-delay round-robin arbiter.
// Holds the FSM state encoding, the LFSR reset seed and the LFSR
// next-state function used by rand_lfsr8.
package rand_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_e;

    localparam logic [7:0] LFSR_RESET = 8'hFF;

    // One shift of the 8-bit Fibonacci LFSR (taps 4,3,2,0 feed the MSB).
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

endpackage

// File: rtl/rand_lfsr8.sv
// 8-bit LFSR with synchronous reset to LFSR_RESET, a parallel load and a
// single-shift step enable. Load wins over step.
module rand_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic [7:0] q
);
    import rand_arb_pkg::*;

    logic [7:0] s_q, s_d;

    // Next LFSR value: parallel load, one shift, or hold.
    always_comb begin
        s_d = s_q;
        if (load) begin
            s_d = load_data;
        end else if (step) begin
            s_d = lfsr_next(s_q);
        end
    end

    // LFSR register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= LFSR_RESET;
        end else begin
            s_q <= s_d;
        end
    end

    assign q = s_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter that delays every grant by a fixed number of LFSR
// shifts and hands the resulting random byte to the granted requester.
// Optional runtime seeding of the LFSR is enabled by defining
// RAND_ARBITER_SEED_LOAD_EN (adds seed_valid/seed_data/seed_ready).
module rand_arbiter #(
    parameter int NREQ  = 4,
    parameter int STEPS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      rnd_data,
    output logic            rnd_valid,
    output logic            busy
`ifdef RAND_ARBITER_SEED_LOAD_EN
    ,
    input  logic            seed_valid,
    input  logic [7:0]      seed_data,
    output logic            seed_ready
`endif
);
    import rand_arb_pkg::*;

    localparam int              IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      LAST_STEP = 8'(STEPS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;

    logic [IDX_W-1:0]  rr_idx;
    logic [IDX_W-1:0]  rr_pick;
    logic              rr_found;

    logic              lfsr_step;
    logic              lfsr_load;
    logic [7:0]        lfsr_load_data;
    logic [7:0]        lfsr_q;

    rand_lfsr8 u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .step      (lfsr_step),
        .load      (lfsr_load),
        .load_data (lfsr_load_data),
        .q         (lfsr_q)
    );

`ifdef RAND_ARBITER_SEED_LOAD_EN
    // Seeds are only accepted while idle; a zero seed would lock the LFSR,
    // so it is replaced by the reset value.
    always_comb begin
        seed_ready     = (state_q == IDLE);
        lfsr_load      = seed_valid && seed_ready;
        lfsr_load_data = (seed_data == 8'h00) ? LFSR_RESET : seed_data;
    end
`else
    // Without runtime seeding the LFSR is only ever seeded by reset.
    always_comb begin
        lfsr_load      = 1'b0;
        lfsr_load_data = LFSR_RESET;
    end
`endif

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        rr_pick  = ptr_q;
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            rr_idx = IDX_W'((int'(ptr_q) + i) % NREQ);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // FSM next state and registered-output next values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        valid_d   = 1'b0;
        data_d    = data_q;
        lfsr_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    win_d   = rr_pick;
                    cnt_d   = 8'd0;
                    state_d = STEP;
                end
            end
            STEP: begin
                lfsr_step = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = IDLE;
                // A requester that gave up while waiting gets nothing and
                // keeps its round-robin position.
                if (req[win_q]) begin
                    gnt_d   = ONE_HOT0 << win_q;
                    valid_d = 1'b1;
                    data_d  = lfsr_q;
                    ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= 8'd0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = valid_q;
    assign rnd_data  = data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed testbench for rand_arbiter (NREQ=4, STEPS=8).
// Seeding tests are compiled when RAND_ARBITER_SEED_LOAD_EN is defined.
module tb_rand_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       busy;
`ifdef RAND_ARBITER_SEED_LOAD_EN
    logic       seed_valid = 1'b0;
    logic [7:0] seed_data  = 8'h00;
    logic       seed_ready;
`endif

    rand_arbiter #(.NREQ(4), .STEPS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .busy      (busy)
`ifdef RAND_ARBITER_SEED_LOAD_EN
        ,
        .seed_valid(seed_valid),
        .seed_data (seed_data),
        .seed_ready(seed_ready)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    vec_t       tbl[10];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] mdl;
    logic [7:0] prev;
    logic       quiet;
    logic       busy_ok;

    function automatic logic [7:0] mstep(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    task automatic adv8();
        for (int k = 0; k < 8; k++) mdl = mstep(mdl);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        mdl = 8'hFF;
    endtask

    // One full request: 9 silent cycles, then the grant pulse on the 10th.
    task automatic run_txn(input logic [3:0] r, input logic [3:0] eg, input string nm);
        req     = r;
        quiet   = 1'b1;
        busy_ok = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (gnt !== 4'b0000 || rnd_valid !== 1'b0) quiet = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({nm, "_quiet"}, quiet, 1'b1);
        chk({nm, "_busy"}, busy_ok, 1'b1);
        tick();
        adv8();
        chk({nm, "_gnt"}, gnt, eg);
        chk({nm, "_data"}, rnd_data, mdl);
        chk({nm, "_valid"}, rnd_valid, 1'b1);
        chk({nm, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        tbl[0] = '{4'b1111, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b1111, 4'b0100};
        tbl[3] = '{4'b1111, 4'b1000};
        tbl[4] = '{4'b1111, 4'b0001};
        tbl[5] = '{4'b0110, 4'b0010};
        tbl[6] = '{4'b1001, 4'b1000};
        tbl[7] = '{4'b1010, 4'b0010};
        tbl[8] = '{4'b0001, 4'b0001};
        tbl[9] = '{4'b1100, 4'b0100};

        // Reset state
        do_reset();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_valid", rnd_valid, 1'b0);
        chk("rst_data", rnd_data, 8'h00);
        chk("rst_busy", busy, 1'b0);

        // First grant from reset carries D0
        run_txn(4'b0001, 4'b0001, "first");
        chk("first_d0", rnd_data, 8'hD0);
        req = 4'b0000;
        tick();
        chk("pulse_gnt", gnt, 4'b0000);
        chk("pulse_valid", rnd_valid, 1'b0);
        chk("hold_data", rnd_data, 8'hD0);
        chk("hold_busy", busy, 1'b0);

        // Round-robin table, back-to-back with req held
        do_reset();
        for (int v = 0; v < 10; v++) begin
            run_txn(tbl[v].req, tbl[v].gnt, $sformatf("rr%0d", v));
        end
        req = 4'b0000;
        tick();

        // Request changes during STEP do not move the latched winner
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0110;
        for (int t = 3; t <= 9; t++) tick();
        tick();
        adv8();
        chk("latch_gnt", gnt, 4'b0100);
        chk("latch_data", rnd_data, mdl);
        req = 4'b0000;
        tick();

        // Requester drops during the 4th STEP cycle: grant suppressed
        do_reset();
        run_txn(4'b0001, 4'b0001, "pre_drop");
        prev  = mdl;
        req   = 4'b0100;
        quiet = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (gnt !== 4'b0000) quiet = 1'b0;
        end
        req = 4'b0000;
        for (int t = 5; t <= 9; t++) begin
            tick();
            if (gnt !== 4'b0000) quiet = 1'b0;
        end
        chk("drop_grant_busy", busy, 1'b1);
        tick();
        if (gnt !== 4'b0000 || rnd_valid !== 1'b0) quiet = 1'b0;
        adv8();
        chk("drop_no_pulse", quiet, 1'b1);
        chk("drop_busy_low", busy, 1'b0);
        chk("drop_data_hold", rnd_data, prev);
        run_txn(4'b0011, 4'b0010, "ptr_kept");
        req = 4'b0000;
        tick();

        // Reset during STEP aborts and reseeds the LFSR
        do_reset();
        req = 4'b0001;
        for (int t = 1; t <= 5; t++) tick();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        mdl = 8'hFF;
        chk("abort_busy", busy, 1'b0);
        quiet = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (gnt !== 4'b0000 || rnd_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("abort_no_grant", quiet, 1'b1);
        run_txn(4'b0001, 4'b0001, "after_abort");
        chk("after_abort_d0", rnd_data, 8'hD0);

        // Reset in GRANT: no pulse, ptr and rnd_data return to reset values
        req = 4'b0001;
        for (int t = 1; t <= 9; t++) tick();
        chk("in_grant_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        mdl = 8'hFF;
        chk("grant_rst_gnt", gnt, 4'b0000);
        chk("grant_rst_valid", rnd_valid, 1'b0);
        chk("grant_rst_data", rnd_data, 8'h00);
        run_txn(4'b0011, 4'b0001, "ptr_reset");
        req = 4'b0000;
        tick();

`ifdef RAND_ARBITER_SEED_LOAD_EN
        // Zero seed loads FF; seed held through STEP must be ignored
        do_reset();
        chk("seed_ready_idle", seed_ready, 1'b1);
        seed_valid = 1'b1;
        seed_data  = 8'h00;
        mdl        = 8'hFF;
        run_txn(4'b0001, 4'b0001, "seed00");
        chk("seed00_d0", rnd_data, 8'hD0);
        seed_data = 8'h01;
        mdl       = 8'h01;
        req       = 4'b0001;
        tick();
        chk("seed_ready_step", seed_ready, 1'b0);
        for (int t = 2; t <= 9; t++) tick();
        tick();
        seed_valid = 1'b0;
        adv8();
        chk("seed01_gnt", gnt, 4'b0001);
        chk("seed01_data", rnd_data, mdl);
        req = 4'b0000;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
